// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD blocks in this codebase.
//   BCD_DIGIT_W    : width of one packed BCD digit
//   BCD_ADJ_THRESH : digit value at and above which double-dabble adds 3
//   bcd_state_t    : sequencer states of the binary-to-BCD converter
//   bcd_adjust()   : single-digit add-3 correction, reusable by other blocks
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    // A digit of at most 9 becomes at most 12 after correction, so the
    // result always fits back into the same 4 bits.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_adjust(
        input logic [BCD_DIGIT_W-1:0] d
    );
        return (d >= BCD_ADJ_THRESH) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational add-3 correction for one BCD digit, applied ahead of the
// left shift in each double-dabble step.
// Ports:
//   din  : input  [3:0] scratch digit before correction
//   dout : output [3:0] digit after correction (din+3 if din>=5, else din)
// -----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = bcd_adjust(din);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3). One conversion per
// accepted start; the result is held on bcd/overflow until the next done.
// Parameters:
//   IN_W   : width of the unsigned binary input
//   DIGITS : number of BCD output digits (digit 0 is the LSD in bcd[3:0])
// Ports:
//   clk         : input            system clock, rising edge
//   rst_n       : input            asynchronous active-low reset
//   start       : input            conversion request, sampled when busy=0
//   bin         : input  [IN_W]    value to convert, sampled on accept edge
//   busy        : output           conversion in progress
//   done        : output           one-cycle pulse when results update
//   bcd         : output [4*DIGITS] packed BCD result
//   overflow    : output           bin exceeded 10^DIGITS-1 (bcd invalid)
//   digit_blank : output [DIGITS]  leading-zero blank mask
// Optional build macro:
//   BIN_TO_BCD_LZ_BLANK_EN - when defined, digit_blank flags leading zero
//   digits (never digit 0, cleared on overflow); otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = 11,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [IN_W-1:0]               bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow,
    output logic [DIGITS-1:0]             digit_blank
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    bcd_state_t state, state_next;

    logic [IN_W-1:0]  sr;
    logic [BCD_W-1:0] dig;
    logic             ovf_s;
    logic [CNT_W-1:0] count;

    logic             load;
    logic             step;
    logic             finish;

    logic [BCD_W-1:0] adj;
    logic             carry_out;
    logic [BCD_W-1:0] dig_shift;
    logic [IN_W-1:0]  sr_shift;
    logic             ovf_next;

    // Per-digit add-3 correction on the current scratch digits.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One double-dabble step: corrected digits and the shift register move
    // left together; the bit leaving the top digit marks overflow.
    always_comb begin
        {carry_out, dig_shift, sr_shift} = {adj, sr, 1'b0};
        ovf_next = ovf_s | carry_out;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. A start in DONE is accepted directly so
    // a held start gives one result every IN_W+1 cycles.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == '0) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers: shift register, scratch digits, sticky overflow and
    // the step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            dig   <= '0;
            ovf_s <= 1'b0;
            count <= '0;
        end else if (load) begin
            sr    <= bin;
            dig   <= '0;
            ovf_s <= 1'b0;
            count <= CNT_W'(IN_W - 1);
        end else if (step) begin
            sr    <= sr_shift;
            dig   <= dig_shift;
            ovf_s <= ovf_next;
            if (count != '0) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Result registers load only from the final step, so intermediate
    // digits never appear on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (finish) begin
            bcd      <= dig_shift;
            overflow <= ovf_next;
        end
    end

`ifdef BIN_TO_BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_q;

    // A digit is blanked when it and every digit above it are zero. Digit 0
    // is never blanked so a zero result still shows one "0".
    always_comb begin
        logic zero_run;
        blank_next = '0;
        zero_run   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run & (dig_shift[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_next[k] = zero_run;
        end
        if (ovf_next) begin
            blank_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (finish) begin
            blank_q <= blank_next;
        end
    end

    assign digit_blank = blank_q;
`else
    assign digit_blank = '0;
`endif

endmodule
